// File: rtl/swarm_pkg.sv
// Shared AXI field types plus response-beat structs used by the L2 memory responder.
package swarm;
    typedef logic [15:0]  axi_id_t;
    typedef logic [63:0]  axi_addr_t;
    typedef logic [7:0]   axi_len_t;
    typedef logic [2:0]   axi_size_t;
    typedef logic [511:0] axi_data_t;
    typedef logic [63:0]  axi_strb_t;
    typedef logic [1:0]   axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'd0;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'd2;

    typedef logic [57:0] line_t;
    typedef enum logic {ARB_WR, ARB_RD} arb_t;

    typedef struct packed {
        axi_id_t   id;
        axi_resp_t resp;
    } b_beat_t;

    typedef struct packed {
        axi_id_t   id;
        axi_resp_t resp;
        axi_data_t data;
    } r_beat_t;

    // Only single-beat, in-range lines touch the store.
    function automatic logic line_err(line_t line, axi_len_t len, int unsigned depth);
        return (len != 8'd0) || (line >= line_t'(depth));
    endfunction
endpackage

// File: rtl/l2_mem_responder_if.sv
// AXI-style slave bus of the L2 memory responder; slave = responder, master = requester.
interface l2_mem_responder_if;
    import swarm::*;

    axi_id_t   s_awid;
    axi_addr_t s_awaddr;
    axi_len_t  s_awlen;
    axi_size_t s_awsize;
    logic      s_awvalid;
    logic      s_awready;
    axi_id_t   s_wid;
    axi_data_t s_wdata;
    axi_strb_t s_wstrb;
    logic      s_wlast;
    logic      s_wvalid;
    logic      s_wready;
    axi_id_t   s_bid;
    axi_resp_t s_bresp;
    logic      s_bvalid;
    logic      s_bready;
    axi_id_t   s_arid;
    axi_addr_t s_araddr;
    axi_len_t  s_arlen;
    axi_size_t s_arsize;
    logic      s_arvalid;
    logic      s_arready;
    axi_id_t   s_rid;
    axi_data_t s_rdata;
    axi_resp_t s_rresp;
    logic      s_rlast;
    logic      s_rvalid;
    logic      s_rready;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awvalid,
        input  s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_bready, s_arid, s_araddr, s_arlen, s_arsize, s_arvalid, s_rready,
        output s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awvalid,
        output s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_bready, s_arid, s_araddr, s_arlen, s_arsize, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
    );
endinterface

// File: rtl/resp_fifo.sv
// Generic synchronous FIFO; head is visible combinationally while valid_o is high.
module resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/l2_mem_responder.sv
// Single-beat, line-granular AXI memory responder backed by a single-port RAM
// with write/read alternation and bounded B/R response buffering.
module l2_mem_responder
    import swarm::*;
#(
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned RESP_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    l2_mem_responder_if.slave bus
);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(RESP_FIFO_DEPTH + 1);

    logic      aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    axi_id_t   aw_id_q, ar_id_q, rd_id_q;
    line_t     aw_line_q, ar_line_q;
    axi_len_t  aw_len_q, ar_len_q;
    axi_data_t w_data_q, ram_q;
    axi_strb_t w_strb_q;
    logic      rd_pend_q, rd_err_q;
    arb_t      arb_q, arb_d;
    logic      aw_hs, w_hs, ar_hs, wr_elig, rd_elig, wr_sel, rd_sel, wr_err, rd_err;
    logic      b_full, b_valid, r_fifo_valid, r_push, r_pop;
    logic [CW-1:0]   r_count, unused_b_count;
    logic            unused_r_full, unused_sink;
    logic [IDXW-1:0] acc_idx;
    b_beat_t   b_in, b_out;
    r_beat_t   r_pend, r_head, r_out;
    axi_data_t mem [DEPTH];

    assign aw_hs = bus.s_awvalid && !aw_held_q;
    assign w_hs  = bus.s_wvalid && !w_held_q;
    assign ar_hs = bus.s_arvalid && !ar_held_q;
    assign bus.s_awready = !aw_held_q;
    assign bus.s_wready  = !w_held_q;
    assign bus.s_arready = !ar_held_q;

    assign wr_err  = line_err(aw_line_q, aw_len_q, DEPTH);
    assign rd_err  = line_err(ar_line_q, ar_len_q, DEPTH);
    assign wr_elig = aw_held_q && w_held_q && !b_full;
    // A read already in the store pipeline will need an R slot too.
    assign rd_elig = ar_held_q && ((32'(r_count) + 32'(rd_pend_q)) < RESP_FIFO_DEPTH);

    always_comb begin
        wr_sel    = 1'b0;
        rd_sel    = 1'b0;
        arb_d     = arb_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        ar_held_d = ar_held_q;
        if (wr_elig && (!rd_elig || arb_q == ARB_WR)) begin
            wr_sel = 1'b1;
            arb_d  = ARB_RD;
        end else if (rd_elig) begin
            rd_sel = 1'b1;
            arb_d  = ARB_WR;
        end
        if (wr_sel) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (rd_sel) ar_held_d = 1'b0;
        if (aw_hs)  aw_held_d = 1'b1;
        if (w_hs)   w_held_d  = 1'b1;
        if (ar_hs)  ar_held_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            rd_pend_q <= 1'b0;
            arb_q     <= ARB_WR;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            ar_held_q <= ar_held_d;
            rd_pend_q <= rd_sel;
            arb_q     <= arb_d;
        end
        if (aw_hs) begin
            aw_id_q   <= bus.s_awid;
            aw_line_q <= bus.s_awaddr[63:6];
            aw_len_q  <= bus.s_awlen;
        end
        if (w_hs) begin
            w_data_q <= bus.s_wdata;
            w_strb_q <= bus.s_wstrb;
        end
        if (ar_hs) begin
            ar_id_q   <= bus.s_arid;
            ar_line_q <= bus.s_araddr[63:6];
            ar_len_q  <= bus.s_arlen;
        end
        if (rd_sel) begin
            rd_id_q  <= ar_id_q;
            rd_err_q <= rd_err;
        end
    end

    assign acc_idx = wr_sel ? aw_line_q[IDXW-1:0] : ar_line_q[IDXW-1:0];

    always_ff @(posedge clk) begin
        if (wr_sel && !wr_err) begin
            for (int b = 0; b < 64; b++) begin
                if (w_strb_q[b]) mem[acc_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
        end else if (rd_sel && !rd_err) begin
            ram_q <= mem[acc_idx];
        end
    end

    assign b_in = '{id: aw_id_q, resp: wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY};

    resp_fifo #(.WIDTH($bits(b_beat_t)), .DEPTH(RESP_FIFO_DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst),
        .push_i(wr_sel), .data_i(b_in),
        .pop_i(b_valid && bus.s_bready),
        .data_o(b_out), .valid_o(b_valid), .full_o(b_full), .count_o(unused_b_count)
    );

    assign bus.s_bvalid = b_valid;
    assign bus.s_bid    = b_out.id;
    assign bus.s_bresp  = b_out.resp;

    // RAM output bypasses an empty R FIFO so a read costs one cycle; it is
    // parked in the FIFO only when it cannot leave immediately.
    assign r_pend = '{id:   rd_id_q,
                      resp: rd_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY,
                      data: rd_err_q ? '0 : ram_q};
    assign r_pop  = r_fifo_valid && bus.s_rready;
    assign r_push = rd_pend_q && (r_fifo_valid || !bus.s_rready);

    resp_fifo #(.WIDTH($bits(r_beat_t)), .DEPTH(RESP_FIFO_DEPTH)) u_r_fifo (
        .clk(clk), .rst(rst),
        .push_i(r_push), .data_i(r_pend),
        .pop_i(r_pop),
        .data_o(r_head), .valid_o(r_fifo_valid), .full_o(unused_r_full), .count_o(r_count)
    );

    assign r_out        = r_fifo_valid ? r_head : r_pend;
    assign bus.s_rvalid = r_fifo_valid || rd_pend_q;
    assign bus.s_rid    = r_out.id;
    assign bus.s_rresp  = r_out.resp;
    assign bus.s_rdata  = r_out.data;
    assign bus.s_rlast  = 1'b1;

    assign unused_sink = ^{bus.s_wid, bus.s_wlast, bus.s_awsize, bus.s_arsize,
                           bus.s_awaddr[5:0], bus.s_araddr[5:0]};
endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboarded bench: drivers push expected B/R beats from a line-level memory model,
// a negedge monitor pops and compares every response handshake.
module tb_l2_mem_responder;
    import swarm::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RFD   = 2;

    typedef struct {
        axi_id_t   id;
        axi_resp_t resp;
        axi_data_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_mem_responder_if bus();

    l2_mem_responder #(.DEPTH(DEPTH), .RESP_FIFO_DEPTH(RFD)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t      exp_b[$];
    exp_t      exp_r[$];
    axi_data_t mdl[int];
    int        checks = 0;
    int        failures = 0;
    int        cyc = 0;
    int        aw_hs, w_hs, ar_hs, b_cyc, r_cyc, ar_cnt, overlap;
    bit        alt_on = 0;
    bit        rand_ready = 0;
    int        alt_seq[$];

    always @(posedge clk) cyc++;

    // ---------------- monitor / scoreboard ----------------
    exp_t      e;
    bit        pb_v, pb_r, pr_v, pr_r;
    axi_id_t   pb_id, pr_id;
    axi_resp_t pb_resp, pr_resp;
    axi_data_t pr_data;

    always @(negedge clk) begin
        if (rst) begin
            pb_v = 0;
            pr_v = 0;
        end else begin
            if (bus.s_awvalid && bus.s_awready) aw_hs = cyc;
            if (bus.s_wvalid && bus.s_wready) w_hs = cyc;
            if (bus.s_arvalid && bus.s_arready) begin
                ar_hs = cyc;
                ar_cnt++;
            end
            if (pb_v && !pb_r) begin
                checks++;
                if (!(bus.s_bvalid && bus.s_bid == pb_id && bus.s_bresp == pb_resp)) begin
                    failures++;
                    $display("FAIL b_stable: got v=%0b id=%h resp=%0d, want v=1 id=%h resp=%0d",
                             bus.s_bvalid, bus.s_bid, bus.s_bresp, pb_id, pb_resp);
                end
            end
            if (pr_v && !pr_r) begin
                checks++;
                if (!(bus.s_rvalid && bus.s_rid == pr_id && bus.s_rresp == pr_resp && bus.s_rdata == pr_data)) begin
                    failures++;
                    $display("FAIL r_stable: got v=%0b id=%h resp=%0d, want v=1 id=%h resp=%0d",
                             bus.s_rvalid, bus.s_rid, bus.s_rresp, pr_id, pr_resp);
                end
            end
            if (alt_on && bus.s_bvalid && bus.s_rvalid) overlap++;
            if (bus.s_bvalid && bus.s_bready) begin
                b_cyc = cyc;
                if (alt_on) alt_seq.push_back(0);
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected: got id=%h resp=%0d, want no response", bus.s_bid, bus.s_bresp);
                end else begin
                    e = exp_b.pop_front();
                    if (bus.s_bid != e.id || bus.s_bresp != e.resp) begin
                        failures++;
                        $display("FAIL b_beat: got id=%h resp=%0d, want id=%h resp=%0d",
                                 bus.s_bid, bus.s_bresp, e.id, e.resp);
                    end
                end
            end
            if (bus.s_rvalid && bus.s_rready) begin
                r_cyc = cyc;
                if (alt_on) alt_seq.push_back(1);
                checks++;
                if (exp_r.size() == 0) begin
                    failures++;
                    $display("FAIL r_unexpected: got id=%h resp=%0d, want no response", bus.s_rid, bus.s_rresp);
                end else begin
                    e = exp_r.pop_front();
                    if (bus.s_rid != e.id || bus.s_rresp != e.resp || bus.s_rlast !== 1'b1 || bus.s_rdata != e.data) begin
                        failures++;
                        $display("FAIL r_beat: got id=%h resp=%0d last=%0b data=%h want id=%h resp=%0d last=1 data=%h",
                                 bus.s_rid, bus.s_rresp, bus.s_rlast, bus.s_rdata, e.id, e.resp, e.data);
                    end
                end
            end
            pb_v = bus.s_bvalid; pb_r = bus.s_bready; pb_id = bus.s_bid; pb_resp = bus.s_bresp;
            pr_v = bus.s_rvalid; pr_r = bus.s_rready; pr_id = bus.s_rid; pr_resp = bus.s_rresp;
            pr_data = bus.s_rdata;
        end
    end

    // Random backpressure on B and R while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) begin
            bus.s_bready = ($urandom_range(0, 3) != 0);
            bus.s_rready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic axi_data_t rand_line();
        axi_data_t d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic wait_hs(string name, ref logic rdy);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rdy) break;
            if (++n > 200) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: got no ready after %0d cycles, want ready", name, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(axi_id_t id, axi_addr_t addr, axi_len_t len);
        bus.s_awid = id; bus.s_awaddr = addr; bus.s_awlen = len; bus.s_awsize = 3'd6;
        bus.s_awvalid = 1'b1;
        wait_hs("aw", bus.s_awready);
        bus.s_awvalid = 1'b0;
    endtask

    task automatic do_w(axi_data_t data, axi_strb_t strb);
        bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wlast = 1'b1; bus.s_wid = '0;
        bus.s_wvalid = 1'b1;
        wait_hs("w", bus.s_wready);
        bus.s_wvalid = 1'b0;
    endtask

    task automatic do_ar(axi_id_t id, axi_addr_t addr, axi_len_t len);
        bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arsize = 3'd6;
        bus.s_arvalid = 1'b1;
        wait_hs("ar", bus.s_arready);
        bus.s_arvalid = 1'b0;
    endtask

    // Model: a line is addr/64; out-of-range or multi-beat requests are errors.
    task automatic wr_op(axi_id_t id, axi_addr_t addr, axi_len_t len, axi_data_t data,
                         axi_strb_t strb, int aw_gap, int w_gap);
        longint unsigned line = addr >> 6;
        bit err = (len != 0) || (line >= DEPTH);
        axi_data_t cur;
        if (!err) begin
            cur = mdl.exists(int'(line)) ? mdl[int'(line)] : '0;
            for (int b = 0; b < 64; b++) if (strb[b]) cur[b*8 +: 8] = data[b*8 +: 8];
            mdl[int'(line)] = cur;
        end
        exp_b.push_back('{id, err ? 2'd2 : 2'd0, '0});
        fork
            begin tick(aw_gap); do_aw(id, addr, len); end
            begin tick(w_gap); do_w(data, strb); end
        join
    endtask

    task automatic rd_op(axi_id_t id, axi_addr_t addr, axi_len_t len);
        longint unsigned line = addr >> 6;
        bit err = (len != 0) || (line >= DEPTH);
        exp_r.push_back('{id, err ? 2'd2 : 2'd0, err ? '0 : mdl[int'(line)]});
        do_ar(id, addr, len);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (exp_b.size() != 0 || exp_r.size() != 0) begin
            tick(1);
            if (++n > budget) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d B and %0d R outstanding, want 0",
                         exp_b.size(), exp_r.size());
                exp_b.delete();
                exp_r.delete();
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
        bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
        bus.s_wid = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 0;
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
        bus.s_bready = 1; bus.s_rready = 1;
        rst = 1;
        tick(3);
        rst = 0;
        @(negedge clk);
        check("rst_bvalid", bus.s_bvalid, 0);
        check("rst_rvalid", bus.s_rvalid, 0);
        check("rst_awready", bus.s_awready, 1);
        check("rst_wready", bus.s_wready, 1);
        check("rst_arready", bus.s_arready, 1);
        tick(1);

        for (int l = 0; l < 8; l++) wr_op(16'($urandom), 64'(l) << 6, 0, rand_line(), '1, 0, 0);
        wait_drain(200);

        // AW and W in the same cycle
        wr_op(16'h1005, 64'h40, 0, {64{8'hAA}}, '1, 0, 0);
        wait_drain(50);
        check("b_latency_same_cycle", b_cyc - ((aw_hs > w_hs) ? aw_hs : w_hs), 2);

        // W three cycles ahead of AW
        wr_op(16'h2003, 64'hC0, 0, rand_line(), '1, 3, 0);
        wait_drain(50);
        check("w_before_aw_gap", aw_hs - w_hs, 3);
        check("b_latency_after_aw", b_cyc - aw_hs, 2);

        // Partial-strobe write, then read back
        wr_op(16'h0011, 64'h80, 0, rand_line(), '1, 0, 0);
        wait_drain(50);
        wr_op(16'h0012, 64'h80, 0, {64{8'h11}}, 64'h0F, 0, 0);
        wait_drain(50);
        rd_op(16'h3001, 64'h80, 0);
        wait_drain(50);
        check("r_latency", r_cyc - ar_hs, 2);

        // Error reads and writes leave the store alone
        rd_op(16'h4001, 64'(DEPTH) * 64, 0);
        rd_op(16'h4002, 64'h80, 1);
        wait_drain(50);
        wr_op(16'h4003, 64'h80, 1, {64{8'hFF}}, '1, 0, 0);
        wr_op(16'h4004, 64'(DEPTH) * 64 + 64'h80, 0, {64{8'hFF}}, '1, 1, 0);
        wait_drain(50);
        rd_op(16'h4005, 64'h80, 0);
        wait_drain(50);

        // R stalled for 20 cycles under continuous AR
        bus.s_rready = 0;
        ar_cnt = 0;
        fork
            for (int i = 0; i < 6; i++) rd_op(16'h5000 + 16'(i), 64'(i) << 6, 0);
            begin
                tick(20);
                check("stall_ar_accepted_le3", (ar_cnt <= 3) ? 1 : 0, 1);
                check("stall_arready_low", bus.s_arready, 0);
                check("stall_rvalid_high", bus.s_rvalid, 1);
                bus.s_rready = 1;
            end
        join
        wait_drain(200);

        // Randomized sequential mix with random backpressure
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 7);
            axi_addr_t addr = (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63));
            axi_len_t len = (k == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            if (k == 1) addr = addr + 64'(DEPTH) * 64;
            if (k == 2) addr[63] = 1'b1;
            if ($urandom_range(0, 1) == 1)
                wr_op(16'($urandom), addr, len, rand_line(), {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd_op(16'($urandom), addr, len);
            wait_drain(300);
        end
        rand_ready = 0;
        tick(1);
        bus.s_bready = 1;
        bus.s_rready = 1;
        tick(2);

        // Reset keeps store contents; then writes and reads compete
        rst = 1;
        tick(2);
        rst = 0;
        @(negedge clk);
        check("rst2_bvalid", bus.s_bvalid, 0);
        check("rst2_awready", bus.s_awready, 1);
        tick(1);
        overlap = 0;
        alt_seq.delete();
        alt_on = 1;
        fork
            for (int i = 0; i < 6; i++) wr_op(16'h6000 + 16'(i), 64'(i % 4) << 6, 0, rand_line(), '1, 0, 0);
            for (int i = 0; i < 6; i++) rd_op(16'h7000 + 16'(i), 64'(4 + i % 4) << 6, 0);
        join
        wait_drain(100);
        alt_on = 0;
        check("alt_overlap", overlap, 0);
        check("alt_events", alt_seq.size(), 12);
        begin
            int bad = 0;
            foreach (alt_seq[i]) if (alt_seq[i] != (i % 2)) bad++;
            check("alt_order_wr_first", bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
